// File: rtl/axi_lite_control_master.sv
// ----------------------------------------------------------------------------
// axi_lite_control_master
//   AXI4-Lite initiator for a kernel's s_axi_control slave. A launch writes the
//   argument words to ARG_BASE.., then writes ap_start (1) to CTRL_ADDR. After
//   that it polls CTRL_ADDR every POLL_INTERVAL cycles until ap_done (bit1) is
//   read back, then pulses finished.
//
// Ports
//   ap_clk, ap_rst_n        clock, async active-low reset
//   launch, args            run request and argument words (word i = args[32*i+:32])
//   busy, finished, error   run status; error is sticky until the next launch
//   polls                   status reads in the current/last run (saturating)
//   AW*/W*/B*/AR*/R*        AXI4-Lite master channels
// ----------------------------------------------------------------------------
// state    | meaning
// IDLE     | waiting for launch
// WR_ADDR  | AW and W presented, each dropped on its own handshake
// WR_RESP  | waiting for B
// WAIT     | poll spacing, down-counter to zero
// RD_ADDR  | AR presented for the control register
// RD_RESP  | waiting for R, inspect ap_done
// DONE     | one-cycle finished pulse
// ----------------------------------------------------------------------------
module axi_lite_control_master #(
    parameter int ADDR_WIDTH    = 6,
    parameter int DATA_WIDTH    = 32,
    parameter int ARG_WORDS     = 4,
    parameter int ARG_BASE      = 'h10,
    parameter int CTRL_ADDR     = 'h00,
    parameter int POLL_INTERVAL = 4
) (
    input  logic                              ap_clk,
    input  logic                              ap_rst_n,
    input  logic                              launch,
    input  logic [ARG_WORDS*DATA_WIDTH-1:0]   args,
    output logic                              busy,
    output logic                              finished,
    output logic                              error,
    output logic [15:0]                       polls,
    output logic                              AWVALID,
    input  logic                              AWREADY,
    output logic [ADDR_WIDTH-1:0]             AWADDR,
    output logic                              WVALID,
    input  logic                              WREADY,
    output logic [DATA_WIDTH-1:0]             WDATA,
    output logic [DATA_WIDTH/8-1:0]           WSTRB,
    input  logic                              BVALID,
    output logic                              BREADY,
    input  logic [1:0]                        BRESP,
    output logic                              ARVALID,
    input  logic                              ARREADY,
    output logic [ADDR_WIDTH-1:0]             ARADDR,
    input  logic                              RVALID,
    output logic                              RREADY,
    input  logic [DATA_WIDTH-1:0]             RDATA,
    input  logic [1:0]                        RRESP
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_WR_ADDR = 3'd1;
    localparam logic [2:0] S_WR_RESP = 3'd2;
    localparam logic [2:0] S_WAIT    = 3'd3;
    localparam logic [2:0] S_RD_ADDR = 3'd4;
    localparam logic [2:0] S_RD_RESP = 3'd5;
    localparam logic [2:0] S_DONE    = 3'd6;

    localparam int IDX_W = $clog2(ARG_WORDS + 1);
    localparam logic [ADDR_WIDTH-1:0] ARG_A  = ADDR_WIDTH'(ARG_BASE);
    localparam logic [ADDR_WIDTH-1:0] CTRL_A = ADDR_WIDTH'(CTRL_ADDR);
    localparam logic [15:0]           WAIT_LOAD = 16'(POLL_INTERVAL - 1);

    logic [2:0]                     state;
    logic [IDX_W-1:0]               idx;
    logic [ARG_WORDS*DATA_WIDTH-1:0] arg_q;
    logic                           aw_valid;
    logic                           w_valid;
    logic                           ar_valid;
    logic [15:0]                    wait_cnt;
    logic [DATA_WIDTH-1:0]          arg_word;
    logic                           is_start;
    logic                           aw_done;
    logic                           w_done;
    logic                           unused_rdata;

    // Only ap_done is of interest in the status word.
    assign unused_rdata = ^{RDATA[DATA_WIDTH-1:2], RDATA[0]};

    // idx == ARG_WORDS marks the ap_start write that follows the arguments.
    assign is_start = (idx == IDX_W'(ARG_WORDS));

    always_comb begin
        arg_word = '0;
        for (int i = 0; i < ARG_WORDS; i++) begin
            if (idx == IDX_W'(i)) begin
                arg_word = arg_q[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Address and data derive only from idx, which moves in WR_RESP, so they
    // hold steady for as long as either VALID is up.
    assign AWADDR  = is_start ? CTRL_A : ARG_A + ADDR_WIDTH'({idx, 2'b00});
    assign WDATA   = is_start ? DATA_WIDTH'(1) : arg_word;
    assign WSTRB   = '1;
    assign AWVALID = aw_valid;
    assign WVALID  = w_valid;
    assign ARVALID = ar_valid;
    assign ARADDR  = CTRL_A;
    assign BREADY  = (state == S_WR_RESP);
    assign RREADY  = (state == S_RD_RESP);
    assign busy    = (state != S_IDLE);
    assign finished = (state == S_DONE);

    // A channel counts as done if it already handshook or handshakes now.
    assign aw_done = !aw_valid || AWREADY;
    assign w_done  = !w_valid  || WREADY;

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state    <= S_IDLE;
            idx      <= '0;
            arg_q    <= '0;
            aw_valid <= 1'b0;
            w_valid  <= 1'b0;
            ar_valid <= 1'b0;
            wait_cnt <= '0;
            error    <= 1'b0;
            polls    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (launch) begin
                        arg_q    <= args;
                        idx      <= '0;
                        error    <= 1'b0;
                        polls    <= '0;
                        aw_valid <= 1'b1;
                        w_valid  <= 1'b1;
                        state    <= S_WR_ADDR;
                    end
                end
                S_WR_ADDR: begin
                    if (aw_valid && AWREADY) aw_valid <= 1'b0;
                    if (w_valid && WREADY)   w_valid  <= 1'b0;
                    if (aw_done && w_done)   state    <= S_WR_RESP;
                end
                S_WR_RESP: begin
                    if (BVALID) begin
                        if (BRESP != 2'b00) error <= 1'b1;
                        if (is_start) begin
                            wait_cnt <= WAIT_LOAD;
                            state    <= S_WAIT;
                        end else begin
                            idx      <= idx + IDX_W'(1);
                            aw_valid <= 1'b1;
                            w_valid  <= 1'b1;
                            state    <= S_WR_ADDR;
                        end
                    end
                end
                S_WAIT: begin
                    if (wait_cnt == 16'd0) begin
                        ar_valid <= 1'b1;
                        state    <= S_RD_ADDR;
                    end else begin
                        wait_cnt <= wait_cnt - 16'd1;
                    end
                end
                S_RD_ADDR: begin
                    if (ARREADY) begin
                        ar_valid <= 1'b0;
                        state    <= S_RD_RESP;
                    end
                end
                S_RD_RESP: begin
                    if (RVALID) begin
                        if (polls != 16'hFFFF) polls <= polls + 16'd1;
                        if (RRESP != 2'b00)    error <= 1'b1;
                        wait_cnt <= WAIT_LOAD;
                        state    <= RDATA[1] ? S_DONE : S_WAIT;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axi_lite_control_master.sv
// ----------------------------------------------------------------------------
// tb_axi_lite_control_master
//   Drives axi_lite_control_master against a behavioural control slave with
//   configurable READY/VALID delays. Expected writes and run results are queued
//   at launch time; a monitor process pops and compares them as the DUT
//   completes writes and pulses finished, and also checks VALID stability.
// ----------------------------------------------------------------------------
module tb_axi_lite_control_master;

    localparam int NW   = 4;
    localparam int DW   = 32;
    localparam int AW   = 6;
    localparam logic [AW-1:0] CTRL = 6'h00;

    typedef struct { logic [AW-1:0] addr; logic [31:0] data; } wr_t;
    typedef struct { int polls; logic err; } run_t;

    logic              ap_clk = 1'b0;
    logic              ap_rst_n = 1'b0;
    logic              launch = 1'b0;
    logic [NW*DW-1:0]  args = '0;
    logic              busy, finished, error;
    logic [15:0]       polls;
    logic              AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
    logic              ARVALID, ARREADY, RVALID, RREADY;
    logic [AW-1:0]     AWADDR, ARADDR;
    logic [DW-1:0]     WDATA, RDATA;
    logic [DW/8-1:0]   WSTRB;
    logic [1:0]        BRESP, RRESP;

    int errors = 0;
    int checks = 0;

    wr_t  exp_wr[$];
    run_t run_q[$];

    always #5 ap_clk = ~ap_clk;

    axi_lite_control_master #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ARG_WORDS(NW),
        .ARG_BASE('h10), .CTRL_ADDR('h00), .POLL_INTERVAL(4)
    ) dut (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .launch(launch), .args(args),
        .busy(busy), .finished(finished), .error(error), .polls(polls),
        .AWVALID(AWVALID), .AWREADY(AWREADY), .AWADDR(AWADDR),
        .WVALID(WVALID), .WREADY(WREADY), .WDATA(WDATA), .WSTRB(WSTRB),
        .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP),
        .ARVALID(ARVALID), .ARREADY(ARREADY), .ARADDR(ARADDR),
        .RVALID(RVALID), .RREADY(RREADY), .RDATA(RDATA), .RRESP(RRESP)
    );

    // ---------------- behavioural slave ----------------
    int aw_fix = 0, w_fix = 0, b_fix = 0, ar_fix = 0, r_fix = 0;
    bit bp_rand = 0;
    bit inj_en = 0;
    logic [AW-1:0] inj_addr = '0;
    int done_n = 3;

    int aw_cnt, aw_need, w_cnt, w_need, ar_cnt, ar_need, b_cnt, b_need, r_cnt, r_need;
    logic s_aw_got, s_w_got, b_pend, r_pend, running;
    logic [AW-1:0] s_awaddr;
    logic [31:0]   s_wdata;
    int reads;

    function automatic int pick(input int fix);
        return bp_rand ? int'($urandom_range(5, 0)) : fix;
    endfunction

    assign AWREADY = AWVALID && (aw_cnt >= aw_need);
    assign WREADY  = WVALID  && (w_cnt  >= w_need);
    assign ARREADY = ARVALID && (ar_cnt >= ar_need);
    assign BVALID  = b_pend  && (b_cnt  >= b_need);
    assign RVALID  = r_pend  && (r_cnt  >= r_need);
    assign RRESP   = 2'b00;

    always @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            aw_cnt <= 0; aw_need <= aw_fix; w_cnt <= 0; w_need <= w_fix;
            ar_cnt <= 0; ar_need <= ar_fix; b_cnt <= 0; b_need <= 0; r_cnt <= 0; r_need <= 0;
            s_aw_got <= 0; s_w_got <= 0; b_pend <= 0; r_pend <= 0; running <= 0;
            s_awaddr <= '0; s_wdata <= '0; BRESP <= 2'b00; RDATA <= '0; reads <= 0;
        end else begin
            if (AWVALID && AWREADY) begin
                s_awaddr <= AWADDR; s_aw_got <= 1; aw_cnt <= 0; aw_need <= pick(aw_fix);
            end else if (AWVALID) aw_cnt <= aw_cnt + 1;
            if (WVALID && WREADY) begin
                s_wdata <= WDATA; s_w_got <= 1; w_cnt <= 0; w_need <= pick(w_fix);
            end else if (WVALID) w_cnt <= w_cnt + 1;
            if (s_aw_got && s_w_got) begin
                s_aw_got <= 0; s_w_got <= 0;
                b_pend <= 1; b_cnt <= 0; b_need <= pick(b_fix);
                BRESP <= (inj_en && s_awaddr == inj_addr) ? 2'b10 : 2'b00;
                if (s_awaddr == CTRL && s_wdata[0]) begin running <= 1; reads <= 0; end
            end else if (b_pend) begin
                if (BVALID && BREADY) b_pend <= 0;
                else b_cnt <= b_cnt + 1;
            end
            if (ARVALID && ARREADY) begin
                ar_cnt <= 0; ar_need <= pick(ar_fix);
                r_pend <= 1; r_cnt <= 0; r_need <= pick(r_fix);
                reads <= reads + 1;
                if (running && reads + 1 >= done_n) begin
                    RDATA <= 32'h6;
                    running <= 0;
                end else begin
                    RDATA <= 32'h0;
                end
            end else begin
                if (ARVALID) ar_cnt <= ar_cnt + 1;
                if (r_pend) begin
                    if (RVALID && RREADY) r_pend <= 0;
                    else r_cnt <= r_cnt + 1;
                end
            end
        end
    end

    // ---------------- checking ----------------
    logic m_aw_got, m_w_got;
    logic [AW-1:0] m_aw;
    logic [31:0]   m_w;
    logic pv_aw, pv_w, pv_ar;
    logic [AW-1:0] pa_aw;
    logic [31:0]   pd_w;
    int bcount;
    int w_first;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic monitor_step();
        wr_t  e;
        run_t r;
        if (!ap_rst_n) begin
            m_aw_got = 0; m_w_got = 0; pv_aw = 0; pv_w = 0; pv_ar = 0; bcount = 0;
            return;
        end
        if (pv_aw) begin
            chk("aw_valid_held", AWVALID, 1);
            chk("aw_addr_stable", AWADDR, pa_aw);
        end
        if (pv_w) begin
            chk("w_valid_held", WVALID, 1);
            chk("w_data_stable", WDATA, pd_w);
        end
        if (pv_ar) chk("ar_valid_held", ARVALID, 1);
        pv_aw = AWVALID && !AWREADY; pa_aw = AWADDR;
        pv_w  = WVALID && !WREADY;   pd_w  = WDATA;
        pv_ar = ARVALID && !ARREADY;
        if (ARVALID && ARREADY) chk("ar_addr", ARADDR, CTRL);
        if (AWVALID && !WVALID) w_first++;
        if (AWVALID && AWREADY) begin m_aw = AWADDR; m_aw_got = 1; end
        if (WVALID && WREADY)   begin m_w = WDATA;   m_w_got = 1; end
        if (m_aw_got && m_w_got) begin
            if (exp_wr.size() == 0) chk("unexpected_write", m_aw, 32'hFFFF_FFFF);
            else begin
                e = exp_wr.pop_front();
                chk("write_addr", m_aw, e.addr);
                chk("write_data", m_w, e.data);
            end
            m_aw_got = 0; m_w_got = 0;
        end
        if (BVALID && BREADY) bcount++;
        if (finished) begin
            if (run_q.size() == 0) chk("unexpected_finished", 0, 1);
            else begin
                r = run_q.pop_front();
                chk("polls", polls, r.polls);
                chk("error", error, r.err);
                chk("b_per_run", bcount, NW + 1);
                chk("writes_left", exp_wr.size(), 0);
            end
            bcount = 0;
        end
    endtask

    task automatic do_reset();
        ap_rst_n = 1'b0;
        repeat (2) @(negedge ap_clk);
        ap_rst_n = 1'b1;
    endtask

    task automatic do_launch(input logic [NW*DW-1:0] a, input int nreads, input logic exp_err);
        @(negedge ap_clk);
        args = a; launch = 1'b1; done_n = nreads;
        for (int i = 0; i < NW; i++) exp_wr.push_back(wr_t'{AW'(16 + 4*i), a[32*i +: 32]});
        exp_wr.push_back(wr_t'{CTRL, 32'h1});
        run_q.push_back(run_t'{nreads, exp_err});
        @(negedge ap_clk);
        launch = 1'b0;
        chk("busy_after_launch", busy, 1);
    endtask

    task automatic wait_idle(input string nm);
        int n = 0;
        while ((busy || run_q.size() != 0) && n < 3000) begin
            @(negedge ap_clk);
            n++;
        end
        chk({nm, "_completes"}, (n < 3000), 1);
    endtask

    initial begin
        logic [NW*DW-1:0] a1;
        int n;
        fork
            forever begin
                @(negedge ap_clk);
                monitor_step();
            end
        join_none

        // 1: reset state, zero-wait run
        do_reset();
        @(negedge ap_clk);
        chk("rst_awvalid", AWVALID, 0); chk("rst_wvalid", WVALID, 0);
        chk("rst_arvalid", ARVALID, 0); chk("rst_bready", BREADY, 0);
        chk("rst_rready", RREADY, 0);   chk("rst_busy", busy, 0);
        chk("rst_finished", finished, 0); chk("rst_error", error, 0);
        chk("rst_polls", polls, 0);     chk("wstrb", WSTRB, 4'hF);
        do_launch({32'hD, 32'hC, 32'hB, 32'hA}, 3, 1'b0);
        wait_idle("t1");

        // 2: WREADY ahead of AWREADY by 3 cycles
        aw_fix = 3; w_fix = 0;
        do_reset();
        w_first = 0;
        do_launch({32'h4444_0004, 32'h3333_0003, 32'h2222_0002, 32'h1111_0001}, 2, 1'b0);
        wait_idle("t2");
        chk("w_drops_first", (w_first > 0), 1);
        aw_fix = 0;

        // 3: error response on argument word 1, sticky, cleared by next launch
        inj_en = 1; inj_addr = 6'h14;
        do_launch({32'hAAAA_5555, 32'h0F0F_F0F0, 32'hDEAD_BEEF, 32'h1234_5678}, 1, 1'b1);
        wait_idle("t3");
        repeat (3) @(negedge ap_clk);
        chk("error_sticky", error, 1);
        inj_en = 0;
        do_launch({32'h8, 32'h7, 32'h6, 32'h5}, 2, 1'b0);
        chk("error_cleared", error, 0);
        wait_idle("t3b");

        // 4: launch while busy and in DONE are ignored
        a1 = {32'hCAFE_0003, 32'hCAFE_0002, 32'hCAFE_0001, 32'hCAFE_0000};
        do_launch(a1, 3, 1'b0);
        repeat (6) @(negedge ap_clk);
        args = ~a1; launch = 1'b1;
        @(negedge ap_clk);
        launch = 1'b0;
        wait_idle("t4");
        do_launch(a1, 1, 1'b0);
        n = 0;
        while (!finished && n < 3000) begin @(negedge ap_clk); n++; end
        chk("t4_done_seen", finished, 1);
        args = ~a1; launch = 1'b1;
        @(negedge ap_clk);
        launch = 1'b0;
        chk("launch_in_done_ignored", busy, 0);
        repeat (4) @(negedge ap_clk);
        chk("still_idle", busy, 0);

        // 5: random backpressure, 50 launches
        bp_rand = 1;
        for (int k = 0; k < 50; k++) begin
            do_launch({$urandom, $urandom, $urandom, $urandom}, int'($urandom_range(3, 1)), 1'b0);
            wait_idle("t5");
        end
        bp_rand = 0;

        // 6: reset during RD_RESP, then a clean run
        r_fix = 4;
        do_reset();
        do_launch({32'h1, 32'h2, 32'h3, 32'h4}, 3, 1'b0);
        n = 0;
        while (!RREADY && n < 3000) begin @(negedge ap_clk); n++; end
        chk("t6_reached_rd_resp", RREADY, 1);
        #2 ap_rst_n = 1'b0;
        #1;
        chk("mid_rst_awvalid", AWVALID, 0); chk("mid_rst_wvalid", WVALID, 0);
        chk("mid_rst_arvalid", ARVALID, 0); chk("mid_rst_bready", BREADY, 0);
        chk("mid_rst_rready", RREADY, 0);   chk("mid_rst_busy", busy, 0);
        chk("mid_rst_finished", finished, 0); chk("mid_rst_error", error, 0);
        chk("mid_rst_polls", polls, 0);
        exp_wr.delete();
        run_q.delete();
        r_fix = 0;
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        do_launch({32'h9999_0004, 32'h9999_0003, 32'h9999_0002, 32'h9999_0001}, 3, 1'b0);
        wait_idle("t6");

        repeat (3) @(negedge ap_clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
